// File: rtl/fdiv_iter.sv
// Iterative single-precision divider: a 26-cycle restoring mantissa divide, then one
// normalise/round cycle. The result is registered and flagged by a one-cycle valid pulse.
module fdiv_iter (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        en,
    output logic [31:0] y,
    output logic        idle,
    output logic        valid
);

    // Handshake: en is sampled only while idle=1. An op started that way raises valid
    // for exactly one cycle, 28 cycles later. y holds its value until the next valid.
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [25:0] rem;
    logic [25:0] quo;
    logic [4:0]  cnt;

    logic        accept;
    logic [25:0] mb;
    logic [25:0] rem_cur;
    logic [25:0] diff;
    logic        ge;

    logic               sgn;
    logic signed [9:0]  e_diff;
    logic signed [9:0]  exp_pre;
    logic signed [9:0]  exp_fin;
    logic [23:0]        mant_sum;
    logic [22:0]        mant_fin;
    logic [31:0]        y_calc;

    assign accept = ((state == S_IDLE) || (state == S_DONE)) && en;
    assign idle   = (state == S_IDLE) || (state == S_DONE);
    assign valid  = (state == S_DONE);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (en) next_state = S_DIV;
            S_DIV:  if (cnt == 5'd25) next_state = S_NORM;
            S_NORM: next_state = S_DONE;
            S_DONE: next_state = en ? S_DIV : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // The first step seeds the partial remainder with the dividend mantissa.
    always_comb begin
        mb      = {2'b01, b_q[22:0]};
        rem_cur = (cnt == 5'd0) ? {2'b01, a_q[22:0]} : rem;
        diff    = rem_cur - mb;
        ge      = (rem_cur >= mb);
    end

    always_comb begin
        sgn    = a_q[31] ^ b_q[31];
        e_diff = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]});
        if (quo[25]) begin
            exp_pre  = e_diff + 10'sd127;
            mant_sum = {1'b0, quo[24:2]} + {23'd0, quo[1]};
        end else begin
            exp_pre  = e_diff + 10'sd126;
            mant_sum = {1'b0, quo[23:1]} + {23'd0, quo[0]};
        end
        // A rounding carry out of the mantissa bumps the exponent and zeroes the fraction.
        exp_fin  = exp_pre + $signed({9'd0, mant_sum[23]});
        mant_fin = mant_sum[23] ? 23'd0 : mant_sum[22:0];

        if (b_q[30:0] == 31'd0)
            y_calc = {sgn, 8'hFF, 23'd0};
        else if (a_q[30:0] == 31'd0)
            y_calc = 32'd0;
        else if (exp_fin <= 10'sd0)
            y_calc = {sgn, 31'd0};
        else if (exp_fin >= 10'sd255)
            y_calc = {sgn, 8'hFF, 23'd0};
        else
            y_calc = {sgn, exp_fin[7:0], mant_fin};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            rem   <= 26'd0;
            quo   <= 26'd0;
            cnt   <= 5'd0;
            y     <= 32'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_q <= x1;
                b_q <= x2;
                rem <= 26'd0;
                quo <= 26'd0;
                cnt <= 5'd0;
            end else if (state == S_DIV) begin
                quo <= {quo[24:0], ge};
                rem <= ge ? {diff[24:0], 1'b0} : {rem_cur[24:0], 1'b0};
                cnt <= cnt + 5'd1;
            end else if (state == S_NORM) begin
                y <= y_calc;
            end
        end
    end

endmodule

// File: tb/tb_fdiv_iter.sv
// Bench for fdiv_iter: directed and random divides checked against a plain-arithmetic
// reference model, plus latency, reset-abort, ignored-en and back-to-back checks.
module tb_fdiv_iter;

  logic        clk;
  logic        rstn;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        en;
  logic [31:0] y;
  logic        idle;
  logic        valid;

  logic [31:0] exp_q[$];
  logic [31:0] prev_y;
  int          n_checks;
  int          n_err;

  fdiv_iter dut (
    .clk   (clk),
    .rstn  (rstn),
    .x1    (x1),
    .x2    (x2),
    .en    (en),
    .y     (y),
    .idle  (idle),
    .valid (valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: exact integer quotient, then the rounding/exponent rules
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic    s;
    longint  ma;
    longint  mb;
    longint  q;
    longint  m;
    int      e;
    logic [7:0] e8;
    s  = a[31] ^ b[31];
    if (b[30:0] == 31'd0) return {s, 8'hFF, 23'd0};
    if (a[30:0] == 31'd0) return 32'd0;
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    q  = (ma * (64'd1 << 25)) / mb;
    e  = int'(a[30:23]) - int'(b[30:23]);
    if (q >= (64'd1 << 25)) begin
      m = ((q >> 2) & 64'h7FFFFF) + ((q >> 1) & 64'd1);
      e = e + 127;
    end else begin
      m = ((q >> 1) & 64'h7FFFFF) + (q & 64'd1);
      e = e + 126;
    end
    if (m == (64'd1 << 23)) begin
      m = 0;
      e = e + 1;
    end
    if (e <= 0)   return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    e8 = e[7:0];
    return {s, e8, m[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // driver: call just after a negedge; returns just after the accepting posedge
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    x1 = a;
    x2 = b;
    en = 1'b1;
    @(posedge clk);
    exp_q.push_back(ref_div(a, b));
    #1 en = 1'b0;
  endtask

  // waits for valid with a cycle budget; checks latency, hold of old y and result
  task automatic wait_result(input string tag);
    logic [31:0] expv;
    bit          seen;
    seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_busy"}, {31'd0, idle}, 32'd0);
      if (c == 14) check({tag, "_hold"}, y, prev_y);
      if (valid) begin
        seen = 1;
        check({tag, "_lat"}, c, 32'd28);
        expv = exp_q.pop_front();
        check({tag, "_y"}, y, expv);
        check({tag, "_idle"}, {31'd0, idle}, 32'd1);
        prev_y = expv;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    issue(a, b);
    wait_result(tag);
    after_done(tag);
  endtask

  initial begin
    int n_valid;
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks = 0;
    n_err    = 0;
    prev_y   = 32'd0;
    rstn = 1'b0;
    en   = 1'b1;
    x1   = 32'h3F80_0000;
    x2   = 32'h4000_0000;

    // reset has priority over en
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_y", y, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    en   = 1'b0;
    rstn = 1'b1;
    n_valid = 0;
    repeat (5) begin
      @(negedge clk);
      n_valid += int'(valid);
    end
    check("no_valid_before_en", n_valid, 32'd0);

    // directed
    run_op("d_6_2",     32'h40C0_0000, 32'h4000_0000);
    run_op("d_1_3",     32'h3F80_0000, 32'h4040_0000);
    run_op("d_neg",     32'hBFC0_0000, 32'h3F00_0000);
    run_op("d_zero",    32'h0000_0000, 32'h4000_0000);
    run_op("d_divzero", 32'h3F80_0000, 32'h0000_0000);
    run_op("d_ovf",     32'h7F00_0000, 32'h0080_0000);
    run_op("d_unf",     32'h0080_0000, 32'h7F00_0000);
    run_op("d_zz",      32'h8000_0000, 32'h8000_0000);
    run_op("d_carry",   32'h3FFF_FFFF, 32'h3F80_0001);

    // reset mid-operation aborts with no valid
    @(negedge clk);
    issue(32'h4120_0000, 32'h4040_0000);
    void'(exp_q.pop_front());
    repeat (9) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_idle", {31'd0, idle}, 32'd1);
    check("abort_y", y, 32'd0);
    prev_y = 32'd0;
    rstn = 1'b1;
    n_valid = 0;
    repeat (35) begin
      @(negedge clk);
      n_valid += int'(valid);
    end
    check("abort_no_valid", n_valid, 32'd0);

    // en held high through DIV: one op only
    x1 = 32'h4140_0000;
    x2 = 32'hC080_0000;
    en = 1'b1;
    exp_q.push_back(ref_div(x1, x2));
    repeat (20) @(negedge clk);
    en = 1'b0;
    n_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) begin
        n_valid++;
        check("held_en_y", y, exp_q.pop_front());
        prev_y = y;
      end
    end
    check("held_en_count", n_valid, 32'd1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    prev_y = ref_div(32'h4140_0000, 32'hC080_0000);

    // back-to-back: en raised in the DONE cycle
    @(negedge clk);
    issue(32'h4040_0000, 32'h4000_0000);
    wait_result("b2b_first");
    issue(32'h4100_0000, 32'h3E80_0000);
    wait_result("b2b_second");
    after_done("b2b_second");

    // random operands, half with exponents kept in the normal result range
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) begin
        ra[30:23] = 8'($urandom_range(100, 154));
        rb[30:23] = 8'($urandom_range(100, 154));
      end
      @(negedge clk);
      issue(ra, rb);
      wait_result($sformatf("rnd%0d", i));
    end
    after_done("rnd_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
